// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Measures the period and high time of a divided clock that is synchronous
// to i_clk. Declares lock once the period has repeated LOCK_CNT times, and
// raises a sticky timeout when the divided clock stops toggling.
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_CNT   = 3,
    parameter int MAX_PERIOD = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_div_clk,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout
);

    localparam int               RUN_W  = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_PERIOD);
    localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEAS   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             r_div_d;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_hi;
    logic [RUN_W-1:0] r_run;

    logic             div_rise;
    logic             per_sat;
    logic [CNT_W-1:0] per_nxt;
    logic [CNT_W-1:0] hi_nxt;
    logic [RUN_W-1:0] run_cap;

    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] high_nxt;
    logic             valid_nxt;
    logic             locked_nxt;
    logic             timeout_nxt;
    logic [RUN_W-1:0] run_nxt;

    // Rising-edge detect and saturating period/high counters
    always_comb begin
        div_rise = i_div_clk & ~r_div_d;
        per_sat  = (r_per >= MAX_V);
        per_nxt  = r_per;
        hi_nxt   = r_hi;
        if (div_rise) begin
            per_nxt = CNT_W'(1);
            hi_nxt  = CNT_W'(1);
        end else begin
            if (!per_sat) begin
                per_nxt = r_per + CNT_W'(1);
            end
            if (i_div_clk && (r_hi < MAX_V)) begin
                hi_nxt = r_hi + CNT_W'(1);
            end
        end
    end

    // Run length that a capture in this cycle would produce
    always_comb begin
        run_cap = RUN_W'(1);
        if ((r_run != '0) && (r_per == o_period)) begin
            run_cap = (r_run >= LOCK_V) ? LOCK_V : (r_run + RUN_W'(1));
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_nxt   = state;
        period_nxt  = o_period;
        high_nxt    = o_high;
        valid_nxt   = 1'b0;
        locked_nxt  = o_locked;
        timeout_nxt = o_timeout;
        run_nxt     = r_run;
        case (state)
            IDLE: begin
                // First edge only arms measurement; the partial period is dropped
                if (div_rise) begin
                    state_nxt   = MEAS;
                    run_nxt     = '0;
                    timeout_nxt = 1'b0;
                end
            end
            MEAS, LOCKED: begin
                // Edge takes priority over a coincident timeout threshold
                if (div_rise) begin
                    period_nxt = r_per;
                    high_nxt   = r_hi;
                    valid_nxt  = 1'b1;
                    run_nxt    = run_cap;
                    if (run_cap == LOCK_V) begin
                        state_nxt  = LOCKED;
                        locked_nxt = 1'b1;
                    end else begin
                        state_nxt  = MEAS;
                        locked_nxt = 1'b0;
                    end
                end else if (per_sat) begin
                    state_nxt   = IDLE;
                    run_nxt     = '0;
                    locked_nxt  = 1'b0;
                    timeout_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_d   <= 1'b0;
            r_per     <= '0;
            r_hi      <= '0;
            r_run     <= '0;
            o_period  <= '0;
            o_high    <= '0;
            o_valid   <= 1'b0;
            o_locked  <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            r_div_d   <= i_div_clk;
            r_per     <= per_nxt;
            r_hi      <= hi_nxt;
            r_run     <= run_nxt;
            o_period  <= period_nxt;
            o_high    <= high_nxt;
            o_valid   <= valid_nxt;
            o_locked  <= locked_nxt;
            o_timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor
// Directed scenarios plus randomized waveforms, checked every cycle against
// an edge-timestamp reference model.
module tb_clk_div_monitor;

    localparam int MAXP  = 255;
    localparam int LOCKN = 3;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_div_clk = 1'b0;
    logic [7:0] o_period;
    logic [7:0] o_high;
    logic       o_valid;
    logic       o_locked;
    logic       o_timeout;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // reference model state
    logic [7:0] e_period  = '0;
    logic [7:0] e_high    = '0;
    logic       e_valid   = 1'b0;
    logic       e_locked  = 1'b0;
    logic       e_timeout = 1'b0;
    logic       m_prev    = 1'b0;
    int         m_last_edge = 0;
    int         m_highs   = 0;
    logic       m_active  = 1'b0;
    int         m_caps[$];

    clk_div_monitor #(.CNT_W(8), .LOCK_CNT(LOCKN), .MAX_PERIOD(MAXP)) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_div_clk (i_div_clk),
        .o_period  (o_period),
        .o_high    (o_high),
        .o_valid   (o_valid),
        .o_locked  (o_locked),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic wbit(input int i, input int hi, input int per);
        return (i % per) < hi;
    endfunction

    // Period = cycles since last rising edge, high = high cycles in that window.
    // Locked = the last LOCKN captured periods since arming are all equal.
    task automatic model_step(input logic d, input logic r);
        int  per;
        int  hi;
        bit  eq;
        if (r) begin
            m_prev = 1'b0; m_last_edge = cyc + 1; m_highs = 0; m_active = 1'b0;
            m_caps.delete();
            e_period = '0; e_high = '0; e_valid = 1'b0; e_locked = 1'b0; e_timeout = 1'b0;
            return;
        end
        per = cyc - m_last_edge;
        if (per > MAXP) per = MAXP;
        hi = (m_highs > MAXP) ? MAXP : m_highs;
        e_valid = 1'b0;
        if (d && !m_prev) begin
            if (!m_active) begin
                m_active  = 1'b1;
                e_timeout = 1'b0;
            end else begin
                e_period = 8'(per);
                e_high   = 8'(hi);
                e_valid  = 1'b1;
                m_caps.push_back(per);
                if (m_caps.size() > LOCKN) void'(m_caps.pop_front());
                eq = (m_caps.size() == LOCKN);
                foreach (m_caps[k]) if (m_caps[k] != m_caps[0]) eq = 0;
                e_locked = eq;
            end
            m_last_edge = cyc;
            m_highs = 1;
        end else begin
            m_highs += int'(d);
            if (m_active && per == MAXP) begin
                m_active = 1'b0;
                m_caps.delete();
                e_timeout = 1'b1;
                e_locked  = 1'b0;
            end
        end
        m_prev = d;
    endtask

    task automatic tick(input logic d, input logic r);
        @(negedge clk);
        i_div_clk = d;
        i_reset   = r;
        @(posedge clk);
        model_step(d, r);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1);
            tests++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !== 19'd0) begin
                fails++;
                $display("FAIL reset cyc %0d got p=%0d h=%0d v=%b l=%b t=%b want all 0",
                         cyc, o_period, o_high, o_valid, o_locked, o_timeout);
            end
        end
    endtask

    task automatic test_div6();
        for (int i = 0; i < 48; i++) begin
            tick(wbit(i, 3, 6), 1'b0);
            tests++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !==
                {e_period, e_high, e_valid, e_locked, e_timeout}) begin
                fails++;
                $display("FAIL div6 cyc %0d got p=%0d h=%0d v=%b l=%b t=%b want p=%0d h=%0d v=%b l=%b t=%b",
                         i, o_period, o_high, o_valid, o_locked, o_timeout,
                         e_period, e_high, e_valid, e_locked, e_timeout);
            end
            if (i == 5 || i == 6) begin
                tests++;
                if (o_valid !== (i == 6) || (i == 6 && {o_period, o_high} !== {8'd6, 8'd3})) begin
                    fails++;
                    $display("FAIL div6_first_valid i=%0d got v=%b p=%0d h=%0d want v=%b p=6 h=3",
                             i, o_valid, o_period, o_high, (i == 6));
                end
            end
            if (i == 17 || i == 18) begin
                tests++;
                if (o_locked !== (i == 18)) begin
                    fails++;
                    $display("FAIL div6_lock i=%0d got %b want %b", i, o_locked, (i == 18));
                end
            end
        end
    endtask

    task automatic test_period_change();
        for (int i = 0; i < 28; i++) begin
            tick((i < 4) ? wbit(i, 2, 4) : wbit(i - 4, 3, 6), 1'b0);
            tests++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !==
                {e_period, e_high, e_valid, e_locked, e_timeout}) begin
                fails++;
                $display("FAIL period_change cyc %0d got p=%0d h=%0d v=%b l=%b t=%b want p=%0d h=%0d v=%b l=%b t=%b",
                         i, o_period, o_high, o_valid, o_locked, o_timeout,
                         e_period, e_high, e_valid, e_locked, e_timeout);
            end
            if (i == 4) begin
                tests++;
                if ({o_valid, o_period, o_locked} !== {1'b1, 8'd4, 1'b0}) begin
                    fails++;
                    $display("FAIL period4_unlock got v=%b p=%0d l=%b want v=1 p=4 l=0",
                             o_valid, o_period, o_locked);
                end
            end
            if (i == 21 || i == 22) begin
                tests++;
                if (o_locked !== (i == 22)) begin
                    fails++;
                    $display("FAIL relock i=%0d got %b want %b", i, o_locked, (i == 22));
                end
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b0);
            tests++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !==
                {e_period, e_high, e_valid, e_locked, e_timeout}) begin
                fails++;
                $display("FAIL timeout cyc %0d got p=%0d h=%0d v=%b l=%b t=%b want p=%0d h=%0d v=%b l=%b t=%b",
                         i, o_period, o_high, o_valid, o_locked, o_timeout,
                         e_period, e_high, e_valid, e_locked, e_timeout);
            end
            if (i == 248 || i == 249) begin
                tests++;
                if ({o_timeout, o_locked} !== ((i == 249) ? 2'b10 : 2'b01)) begin
                    fails++;
                    $display("FAIL timeout_edge i=%0d got t=%b l=%b", i, o_timeout, o_locked);
                end
            end
        end
        for (int j = 0; j < 30; j++) begin
            tick(wbit(j, 3, 6), 1'b0);
            tests++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !==
                {e_period, e_high, e_valid, e_locked, e_timeout}) begin
                fails++;
                $display("FAIL restart cyc %0d got p=%0d h=%0d v=%b l=%b t=%b want p=%0d h=%0d v=%b l=%b t=%b",
                         j, o_period, o_high, o_valid, o_locked, o_timeout,
                         e_period, e_high, e_valid, e_locked, e_timeout);
            end
            if (j == 0) begin
                tests++;
                if ({o_timeout, o_period, o_valid} !== {1'b0, 8'd6, 1'b0}) begin
                    fails++;
                    $display("FAIL timeout_clear got t=%b p=%0d v=%b want t=0 p=6 v=0",
                             o_timeout, o_period, o_valid);
                end
            end
        end
    endtask

    task automatic test_duty5();
        for (int j = 0; j < 40; j++) begin
            tick(wbit(j, 2, 5), 1'b0);
            tests++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !==
                {e_period, e_high, e_valid, e_locked, e_timeout}) begin
                fails++;
                $display("FAIL duty5 cyc %0d got p=%0d h=%0d v=%b l=%b t=%b want p=%0d h=%0d v=%b l=%b t=%b",
                         j, o_period, o_high, o_valid, o_locked, o_timeout,
                         e_period, e_high, e_valid, e_locked, e_timeout);
            end
            if (j >= 5 && (j % 5) == 0) begin
                tests++;
                if ({o_valid, o_period, o_high} !== {1'b1, 8'd5, 8'd2}) begin
                    fails++;
                    $display("FAIL duty5_capture j=%0d got v=%b p=%0d h=%0d want v=1 p=5 h=2",
                             j, o_valid, o_period, o_high);
                end
            end
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 780; i++) begin
            tick((i == 0) || (i == 255) || (i == 510), 1'b0);
            tests++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !==
                {e_period, e_high, e_valid, e_locked, e_timeout}) begin
                fails++;
                $display("FAIL boundary cyc %0d got p=%0d h=%0d v=%b l=%b t=%b want p=%0d h=%0d v=%b l=%b t=%b",
                         i, o_period, o_high, o_valid, o_locked, o_timeout,
                         e_period, e_high, e_valid, e_locked, e_timeout);
            end
            if (i == 255) begin
                tests++;
                if ({o_valid, o_period, o_high, o_timeout} !== {1'b1, 8'd255, 8'd1, 1'b0}) begin
                    fails++;
                    $display("FAIL edge_at_max got v=%b p=%0d h=%0d t=%b want v=1 p=255 h=1 t=0",
                             o_valid, o_period, o_high, o_timeout);
                end
            end
            if (i == 764 || i == 765) begin
                tests++;
                if (o_timeout !== (i == 765)) begin
                    fails++;
                    $display("FAIL timeout_256 i=%0d got %b want %b", i, o_timeout, (i == 765));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 21; i++) begin
            tick(wbit(i, 3, 6), 1'b0);
        end
        tests++;
        if (o_locked !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_lock got %b want 1", o_locked);
        end
        tick(1'b0, 1'b1);
        tests++;
        if ({o_period, o_high, o_valid, o_locked, o_timeout} !== 19'd0) begin
            fails++;
            $display("FAIL mid_reset got p=%0d h=%0d v=%b l=%b t=%b want all 0",
                     o_period, o_high, o_valid, o_locked, o_timeout);
        end
        for (int k = 0; k < 24; k++) begin
            tick(wbit(k, 3, 6), 1'b0);
            tests++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !==
                {e_period, e_high, e_valid, e_locked, e_timeout}) begin
                fails++;
                $display("FAIL reset_mid cyc %0d got p=%0d h=%0d v=%b l=%b t=%b want p=%0d h=%0d v=%b l=%b t=%b",
                         k, o_period, o_high, o_valid, o_locked, o_timeout,
                         e_period, e_high, e_valid, e_locked, e_timeout);
            end
            if (k == 17 || k == 18) begin
                tests++;
                if (o_locked !== (k == 18)) begin
                    fails++;
                    $display("FAIL relock_after_reset k=%0d got %b want %b", k, o_locked, (k == 18));
                end
            end
        end
    endtask

    task automatic test_random();
        int left = 2500;
        int per = 6;
        int hi = 3;
        logic seg_d[$];
        logic seg_r[$];
        while (left > 0) begin
            int sel;
            sel = $urandom_range(0, 63);
            seg_d.delete();
            seg_r.delete();
            if (sel == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
                    seg_d.push_back(1'b0); seg_r.push_back(1'b1);
                end
            end else if (sel < 4) begin
                int gap;
                gap = $urandom_range(250, 260);
                seg_d.push_back(1'b1); seg_r.push_back(1'b0);
                for (int k = 0; k < gap; k++) begin
                    seg_d.push_back(1'b0); seg_r.push_back(1'b0);
                end
            end else begin
                if ($urandom_range(0, 1) == 0) begin
                    per = $urandom_range(2, 20);
                    hi  = $urandom_range(1, per - 1);
                end
                for (int k = 0; k < per; k++) begin
                    seg_d.push_back(wbit(k, hi, per)); seg_r.push_back(1'b0);
                end
            end
            foreach (seg_d[k]) begin
                tick(seg_d[k], seg_r[k]);
                left--;
                tests++;
                if ({o_period, o_high, o_valid, o_locked, o_timeout} !==
                    {e_period, e_high, e_valid, e_locked, e_timeout}) begin
                    fails++;
                    $display("FAIL random cyc %0d got p=%0d h=%0d v=%b l=%b t=%b want p=%0d h=%0d v=%b l=%b t=%b",
                             cyc, o_period, o_high, o_valid, o_locked, o_timeout,
                             e_period, e_high, e_valid, e_locked, e_timeout);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_div6();
        test_period_change();
        test_timeout();
        test_duty5();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
